// File: rtl/relay_pulse_scheduler_pkg.sv
// relay_pulse_scheduler_pkg: shared FSM state type and default coil timing for relay_pulse_scheduler
// Contents:
//   relay_fsm_t       scheduler state (IDLE, PULSE, GAP)
//   DEF_PULSE_CYCLES  coil drive time in clocks (10 ms at 250 MHz)
//   DEF_GAP_CYCLES    dead time after each pulse in clocks (1 ms at 250 MHz)
package RelayTypes;
    typedef enum logic [1:0] {IDLE, PULSE, GAP} relay_fsm_t;
    localparam int DEF_PULSE_CYCLES = 2500000;
    localparam int DEF_GAP_CYCLES   = 250000;
endpackage

// File: rtl/relay_pulse_scheduler_rr_picker.sv
// relay_rr_picker: combinational round-robin picker, first pending channel at or after ptr with wrap-around
// Ports:
//   pending    in  N   per-channel request flags
//   ptr        in  IW  channel with highest priority this round
//   gnt_valid  out 1   some channel is pending
//   gnt_idx    out IW  granted channel (0 when nothing is pending)
module relay_rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] j;
    always_comb begin
        gnt_valid = |pending;
        gnt_idx = '0;
        j = '0;
        // Walk from the farthest offset down so the nearest pending channel is written last.
        for (int i = N - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % N);
            if (pending[j]) gnt_idx = j;
        end
    end
endmodule

// File: rtl/relay_pulse_scheduler.sv
// relay_pulse_scheduler: serves per-relay set/reset requests round-robin, one coil pulse plus dead time at a time
// Optional feature: define RELAY_SKIP_REDUNDANT_EN to drop requests whose direction matches a known relay state.
// Ports:
//   clk          in  1    rising-edge clock
//   rst_n        in  1    asynchronous active-low reset
//   req_valid    in  1    request strobe, one cycle per request
//   req_channel  in  IW   relay index (values >= NUM_RELAYS ignored)
//   req_set      in  1    1 = set (A leg), 0 = reset (B leg)
//   relay_a      out N    H-bridge A legs, registered
//   relay_b      out N    H-bridge B legs, registered
//   relay_state  out N    last completed direction per relay
//   pending      out N    outstanding request flags
//   busy         out 1    pulse or dead time in progress
//   done         out 1    one-cycle strobe in the cycle a drive drops
module relay_pulse_scheduler
    import RelayTypes::*;
#(
    parameter int NUM_RELAYS   = 4,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    input  logic [$clog2(NUM_RELAYS)-1:0] req_channel,
    input  logic                          req_set,
    output logic [NUM_RELAYS-1:0]         relay_a,
    output logic [NUM_RELAYS-1:0]         relay_b,
    output logic [NUM_RELAYS-1:0]         relay_state,
    output logic [NUM_RELAYS-1:0]         pending,
    output logic                          busy,
    output logic                          done
);
    localparam int IW   = $clog2(NUM_RELAYS);
    localparam int MAXC = PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    // The registered legs lag the state by one cycle, so GAP also covers the last driven
    // cycle; loading GAP_CYCLES (not minus one) still leaves GAP_CYCLES all-low cycles.
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES);
    localparam logic [NUM_RELAYS-1:0] ONE = NUM_RELAYS'(1);

    relay_fsm_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [NUM_RELAYS-1:0] target, req_hit, clr, act_oh;
    logic [IW-1:0] ptr, ptr_base, ptr_nx, active_ch, gnt_idx;
    logic active_dir, gnt_valid, start, skip, finish;

    relay_rr_picker #(.N(NUM_RELAYS), .IW(IW)) u_picker (
        .pending  (pending),
        .ptr      (ptr),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx)
    );

    // Out-of-range channels shift the bit off the top and vanish.
    assign req_hit  = req_valid ? ONE << req_channel : '0;
    assign act_oh   = ONE << active_ch;
    assign finish   = state == GAP && cnt == GAP_LOAD;
    assign clr      = (start || skip) ? ONE << gnt_idx : '0;
    assign busy     = state != IDLE;
    assign ptr_base = finish ? active_ch : gnt_idx;
    assign ptr_nx   = ptr_base == IW'(NUM_RELAYS - 1) ? '0 : ptr_base + 1'b1;

`ifdef RELAY_SKIP_REDUNDANT_EN
    logic [NUM_RELAYS-1:0] known;
    assign skip = state == IDLE && gnt_valid && known[gnt_idx] && target[gnt_idx] == relay_state[gnt_idx];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) known <= '0;
        else if (finish) known[active_ch] <= 1'b1;
    end
`else
    assign skip = 1'b0;
`endif
    assign start = state == IDLE && gnt_valid && !skip;

    always_comb begin
        state_nx = state;
        cnt_nx = cnt - 1'b1;
        case (state)
            IDLE: begin
                state_nx = start ? PULSE : IDLE;
                cnt_nx = PULSE_LOAD;
            end
            PULSE: if (cnt == '0) begin
                state_nx = GAP;
                cnt_nx = GAP_LOAD;
            end
            default: if (cnt == '0) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            pending <= '0;
            target <= '0;
            ptr <= '0;
            active_ch <= '0;
            active_dir <= 1'b0;
            relay_a <= '0;
            relay_b <= '0;
            relay_state <= '0;
            done <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            // A capture in the same cycle as the pick of that channel keeps it pending.
            pending <= (pending & ~clr) | req_hit;
            target <= (target & ~req_hit) | ({NUM_RELAYS{req_set}} & req_hit);
            relay_a <= (state == PULSE && active_dir) ? act_oh : '0;
            relay_b <= (state == PULSE && !active_dir) ? act_oh : '0;
            done <= finish;
            if (start) begin
                active_ch <= gnt_idx;
                active_dir <= target[gnt_idx];
            end
            if (finish) relay_state[active_ch] <= active_dir;
            if (finish || skip) ptr <= ptr_nx;
        end
    end
endmodule

// File: tb/tb_relay_pulse_scheduler.sv
// tb_relay_pulse_scheduler: directed and random requests checked against a pulse-timeline reference model
module tb_relay_pulse_scheduler;
    localparam int N = 4, P = 8, G = 4;

    logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_set = 1'b0;
    logic [1:0] req_channel = '0;
    logic [3:0] relay_a, relay_b, relay_state, pending;
    logic busy, done;
    int tests = 0, fails = 0, cyc = 0;

    typedef struct {int e; int ch; bit s;} req_t;
    typedef struct {int st; int ch; bit d; int len;} pl_t;
    req_t rq[$];
    pl_t obs[$];
    pl_t cur;
    logic [3:0] prev_drv = '0;

    relay_pulse_scheduler #(.NUM_RELAYS(N), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_channel(req_channel), .req_set(req_set),
        .relay_a(relay_a), .relay_b(relay_b), .relay_state(relay_state), .pending(pending),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lowidx(input logic [3:0] v);
        lowidx = 0;
        for (int k = 3; k >= 0; k--) if (v[k]) lowidx = k;
    endfunction

    // Per-cycle observer: legs never overlap, pulses are logged, done appears exactly at each drop.
    always @(negedge clk) begin
        logic [3:0] drv;
        drv = relay_a | relay_b;
        if (!rst_n) prev_drv = '0;
        else begin
            chk("one_hot", 32'((drv & (drv - 4'd1)) | (relay_a & relay_b)), 0);
            if (drv != 0 && prev_drv == 0) cur = '{cyc, lowidx(drv), relay_a != 0, 0};
            if (drv != 0) cur.len++;
            if (prev_drv != 0 && drv == 0) begin
                obs.push_back(cur);
                chk("done_at_drop", 32'(done), 1);
                chk("state_at_drop", 32'(relay_state[cur.ch]), 32'(cur.d));
            end else chk("done_spurious", 32'(done), 0);
            prev_drv = drv;
        end
    end

    task automatic send(input int ch, input bit s);
        req_valid = 1'b1;
        req_channel = 2'(ch);
        req_set = s;
        rq.push_back('{cyc + 1, ch, s});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || pending != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 1);
    endtask

    // Timeline model: a pick at edge e serves requests sampled before e, drives cycles
    // e+1..e+P, and the earliest next pick is edge e+P+G+2 (skips cost one edge).
    task automatic check_model(input string tag);
        pl_t ex[$];
        bit pend[N] = '{default: 0};
        bit tgt[N] = '{default: 0};
        bit st[N] = '{default: 0};
        bit kn[N] = '{default: 0};
        int ptr = 0, free_e = 0, ri = 0, e = 0, c = 0;
        bit any;
        logic [3:0] es;
        forever begin
            while (ri < rq.size() && rq[ri].e < e) begin
                pend[rq[ri].ch] = 1;
                tgt[rq[ri].ch] = rq[ri].s;
                ri++;
            end
            any = 0;
            foreach (pend[k]) any |= pend[k];
            if (ri >= rq.size() && !any) break;
            if (e >= free_e && any) begin
                for (int k = 0; k < N; k++) begin
                    c = (ptr + k) % N;
                    if (pend[c]) break;
                end
                pend[c] = 0;
                ptr = (c + 1) % N;
`ifdef RELAY_SKIP_REDUNDANT_EN
                if (kn[c] && tgt[c] == st[c]) free_e = e + 1;
                else begin
                    ex.push_back('{e + 1, c, tgt[c], P});
                    st[c] = tgt[c];
                    kn[c] = 1;
                    free_e = e + P + G + 2;
                end
`else
                ex.push_back('{e + 1, c, tgt[c], P});
                st[c] = tgt[c];
                kn[c] = 1;
                free_e = e + P + G + 2;
`endif
            end
            e++;
        end
        chk({tag, "_count"}, 32'(obs.size()), 32'(ex.size()));
        for (int i = 0; i < ex.size() && i < obs.size(); i++) begin
            chk($sformatf("%s_p%0d_start", tag, i), 32'(obs[i].st), 32'(ex[i].st));
            chk($sformatf("%s_p%0d_ch", tag, i), 32'(obs[i].ch), 32'(ex[i].ch));
            chk($sformatf("%s_p%0d_dir", tag, i), 32'(obs[i].d), 32'(ex[i].d));
            chk($sformatf("%s_p%0d_len", tag, i), 32'(obs[i].len), 32'(ex[i].len));
        end
        es = '0;
        for (int k = 0; k < N; k++) es[k] = st[k];
        chk({tag, "_relay_state"}, 32'(relay_state), 32'(es));
    endtask

    initial begin
        int r;
        #1;
        chk("rst_relay_a", 32'(relay_a), 0);
        chk("rst_relay_b", 32'(relay_b), 0);
        chk("rst_state", 32'(relay_state), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(2, 1'b1);
        r = cyc;
        chk("ch2_pending", 32'(pending), 32'h4);
        at(r + 1);
        chk("ch2_picked", 32'(pending), 0);
        chk("ch2_busy_pick", 32'(busy), 1);
        chk("ch2_no_drive_yet", 32'(relay_a), 0);
        at(r + 2);
        chk("ch2_drive_first", 32'(relay_a), 32'h4);
        chk("ch2_b_low", 32'(relay_b), 0);
        at(r + 9);
        chk("ch2_drive_last", 32'(relay_a), 32'h4);
        at(r + 10);
        chk("ch2_drive_off", 32'(relay_a), 0);
        chk("ch2_done", 32'(done), 1);
        chk("ch2_state", 32'(relay_state), 32'h4);
        at(r + 13);
        chk("ch2_busy_gap_end", 32'(busy), 1);
        at(r + 14);
        chk("ch2_busy_low", 32'(busy), 0);

        send(0, 1'b1);
        send(1, 1'b1);
        send(3, 1'b1);
        wait_idle(200);

        send(2, 1'b0);
        send(1, 1'b1);
        send(1, 1'b0);
        wait_idle(200);
        chk("ch1_latest_wins", 32'(relay_state[1]), 0);

        send(0, 1'b0);
        at(cyc + 4);
        send(0, 1'b1);
        wait_idle(200);
        chk("ch0_requeued", 32'(relay_state[0]), 1);

        repeat (30) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            send(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        wait_idle(2000);
        check_model("seq");

        send(1, 1'b1);
        r = cyc;
        send(2, 1'b1);
        at(r + 5);
        chk("mid_drive", 32'(relay_a), 32'h2);
        chk("mid_pending", 32'(pending), 32'h4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a", 32'(relay_a), 0);
        chk("mid_rst_b", 32'(relay_b), 0);
        chk("mid_rst_state", 32'(relay_state), 0);
        chk("mid_rst_pending", 32'(pending), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        rq.delete();
        obs.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (P + G + 4) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({relay_a | relay_b, pending, busy}), 0);
        end

        send(3, 1'b1);
        wait_idle(200);
        send(3, 1'b1);
        wait_idle(200);
        check_model("repeat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
